// File: rtl/cmem_arbiter.sv
// Round-robin responder that serves the CPU instruction (a) and data (b) cmem
// ports from one downstream memory port, one transaction at a time.
module cmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmem_read_a,
    input  logic                    cmem_write_a,
    input  logic [ADDR_WIDTH-1:0]   cmem_address_a,
    input  logic [DATA_WIDTH-1:0]   cmem_wdata_a,
    input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_a,
    output logic                    cmem_resp_a,
    output logic [DATA_WIDTH-1:0]   cmem_rdata_a,

    input  logic                    cmem_read_b,
    input  logic                    cmem_write_b,
    input  logic [ADDR_WIDTH-1:0]   cmem_address_b,
    input  logic [DATA_WIDTH-1:0]   cmem_wdata_b,
    input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_b,
    output logic                    cmem_resp_b,
    output logic [DATA_WIDTH-1:0]   cmem_rdata_b,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic        PORT_A   = 1'b0;
    localparam logic        PORT_B   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q,      state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    mem_read_q,   mem_read_d;
    logic                    mem_write_q,  mem_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic [BE_WIDTH-1:0]     be_q,         be_d;
    logic                    resp_a_q,     resp_a_d;
    logic                    resp_b_q,     resp_b_d;
    logic [DATA_WIDTH-1:0]   rdata_a_q,    rdata_a_d;
    logic [DATA_WIDTH-1:0]   rdata_b_q,    rdata_b_d;

    logic                    pend_a;
    logic                    pend_b;
    logic                    sel_b;
    logic                    grant_wr;

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_a_d     = 1'b0;
        resp_b_d     = 1'b0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;

        pend_a   = cmem_read_a | cmem_write_a;
        pend_b   = cmem_read_b | cmem_write_b;
        // On contention, the port that did not win last time goes next.
        sel_b    = pend_b & (~pend_a | (last_grant_q == PORT_A));
        // Read+write together is treated as a write.
        grant_wr = sel_b ? cmem_write_b : cmem_write_a;

        unique case (state_q)
            IDLE: begin
                if (pend_a | pend_b) begin
                    last_grant_d = sel_b ? PORT_B : PORT_A;
                    addr_d       = sel_b ? cmem_address_b     : cmem_address_a;
                    wdata_d      = sel_b ? cmem_wdata_b       : cmem_wdata_a;
                    be_d         = sel_b ? cmem_byte_enable_b : cmem_byte_enable_a;
                    mem_read_d   = ~grant_wr;
                    mem_write_d  = grant_wr;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (last_grant_q == PORT_B) begin
                        resp_b_d  = 1'b1;
                        rdata_b_d = mem_rdata;
                    end else begin
                        resp_a_d  = 1'b1;
                        rdata_a_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_A;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_a_q     <= 1'b0;
            resp_b_q     <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_a_q     <= resp_a_d;
            resp_b_q     <= resp_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign cmem_resp_a     = resp_a_q;
    assign cmem_rdata_a    = rdata_a_q;
    assign cmem_resp_b     = resp_b_q;
    assign cmem_rdata_b    = rdata_b_q;

endmodule
